// File: rtl/t_counter.sv
// Parametrised toggle-style up/down counter with programmable terminal value,
// load, clear, wrap/saturate, terminal-count pulse and sticky overflow.
// Optional enable prescaler: define T_COUNTER_PRESCALE_EN.
module t_counter #(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter int unsigned      PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat_mode,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAX_VAL) ? MAX_VAL : v;
  endfunction

  // Value taken at a boundary: hold when saturating, otherwise a forced
  // load to the opposite end so non-power-of-two ranges wrap correctly.
  function automatic logic [WIDTH-1:0] bound_val(input logic [WIDTH-1:0] cur,
                                                 input logic up,
                                                 input logic sat);
    if (sat)
      return cur;
    return up ? '0 : MAX_VAL;
  endfunction

  logic             tick;
  logic             step;
  logic             bnd;
  logic [WIDTH-1:0] tmask;
  logic [WIDTH-1:0] q_nxt;

`ifdef T_COUNTER_PRESCALE_EN
  localparam int unsigned     PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PLAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt;

  assign tick = (pcnt == PLAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pcnt <= '0;
    else if (clr || load)
      pcnt <= '0;
    else if (en)
      pcnt <= tick ? '0 : pcnt + 1'b1;
  end
`else
  // An illegal PRESCALE of 0 disables stepping rather than silently counting.
  assign tick = (PRESCALE != 0);
`endif

  assign step = en & ~clr & ~load & tick;
  assign bnd  = up_dn ? (q == MAX_VAL) : (q == '0);

  // Bit i toggles when all lower bits are 1 (up) or all 0 (down).
  always_comb begin
    tmask    = '0;
    tmask[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++)
      tmask[i] = tmask[i-1] & (up_dn ? q[i-1] : ~q[i-1]);
  end

  assign q_nxt = bnd ? bound_val(q, up_dn, sat_mode) : (q ^ tmask);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q   <= '0;
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (clr)
        q <= '0;
      else if (load)
        q <= clamp_load(load_val);
      else if (step) begin
        q  <= q_nxt;
        tc <= bnd;
      end

      // A boundary event in the same cycle outranks ovf_clr.
      if (step && bnd)
        ovf <= 1'b1;
      else if (ovf_clr)
        ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_t_counter.sv
// Bench for t_counter: two instances (range 0..15 and 0..9) driven in parallel,
// checked against an integer reference model plus hand-computed vectors.
module tb_t_counter;

  localparam int PRESCALE = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, up_dn, sat_mode, clr, load, ovf_clr;
  logic [3:0] load_val;
  logic [3:0] q16, q9;
  logic       tc16, tc9, ovf16, ovf9;

  int checks = 0;
  int errors = 0;

  int mq[2], mtc[2], movf[2], mp[2];

  typedef struct {
    bit         en, up, sat, clr, ld;
    logic [3:0] lv;
    bit         oc;
    int         eq, etc, eov;
  } vec_t;

  vec_t vt[16];

  always #5 clk = ~clk;

  t_counter #(.WIDTH(4), .MAX_VAL(4'd15), .PRESCALE(PRESCALE)) u_dut16 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat_mode(sat_mode),
    .clr(clr), .load(load), .load_val(load_val), .ovf_clr(ovf_clr),
    .q(q16), .tc(tc16), .ovf(ovf16)
  );

  t_counter #(.WIDTH(4), .MAX_VAL(4'd9), .PRESCALE(PRESCALE)) u_dut9 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat_mode(sat_mode),
    .clr(clr), .load(load), .load_val(load_val), .ovf_clr(ovf_clr),
    .q(q9), .tc(tc9), .ovf(ovf9)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i] = 0; mtc[i] = 0; movf[i] = 0; mp[i] = 0;
    end
  endtask

  // Behavioural model of one clock edge, from the counting rules.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int mx;
      bit tk, bnd;
      mx  = (i == 0) ? 15 : 9;
      tk  = 1'b1;
`ifdef T_COUNTER_PRESCALE_EN
      tk  = (mp[i] == PRESCALE - 1);
`endif
      bnd = 1'b0;
      if (clr) begin
        mq[i] = 0; mtc[i] = 0; mp[i] = 0;
      end else if (load) begin
        mq[i] = (int'(load_val) > mx) ? mx : int'(load_val);
        mtc[i] = 0; mp[i] = 0;
      end else begin
        if (en) begin
          mp[i] = tk ? 0 : mp[i] + 1;
          if (tk) begin
            if (up_dn) begin
              if (mq[i] == mx) begin bnd = 1'b1; if (!sat_mode) mq[i] = 0; end
              else mq[i] = mq[i] + 1;
            end else begin
              if (mq[i] == 0) begin bnd = 1'b1; if (!sat_mode) mq[i] = mx; end
              else mq[i] = mq[i] - 1;
            end
          end
        end
        mtc[i] = bnd ? 1 : 0;
      end
      if (bnd) movf[i] = 1;
      else if (ovf_clr) movf[i] = 0;
    end
  endtask

  task automatic check_model();
    chk("model_q16",   q16,   mq[0]);
    chk("model_tc16",  tc16,  mtc[0]);
    chk("model_ovf16", ovf16, movf[0]);
    chk("model_q9",    q9,    mq[1]);
    chk("model_tc9",   tc9,   mtc[1]);
    chk("model_ovf9",  ovf9,  movf[1]);
  endtask

  // One clock: model the edge, sample 1 time unit later, leave at edge+2.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
    #1;
  endtask

  task automatic set_in(input bit e, input bit u, input bit s, input bit c,
                        input bit l, input logic [3:0] lv, input bit oc);
    en = e; up_dn = u; sat_mode = s; clr = c; load = l; load_val = lv; ovf_clr = oc;
  endtask

  initial begin
    vt[0]  = '{1,1,1,0,1,4'd7, 0, 7,0,0};
    vt[1]  = '{1,1,1,0,0,4'd0, 0, 8,0,0};
    vt[2]  = '{1,1,1,0,0,4'd0, 0, 9,0,0};
    vt[3]  = '{1,1,1,0,0,4'd0, 0, 9,1,1};
    vt[4]  = '{1,1,1,0,0,4'd0, 0, 9,1,1};
    vt[5]  = '{0,1,1,0,0,4'd0, 1, 9,0,0};
    vt[6]  = '{0,1,1,1,0,4'd0, 0, 0,0,0};
    vt[7]  = '{1,1,1,0,1,4'd12,0, 9,0,0};
    vt[8]  = '{1,1,1,1,1,4'd12,0, 0,0,0};
    vt[9]  = '{0,0,0,0,1,4'd1, 0, 1,0,0};
    vt[10] = '{1,0,0,0,0,4'd0, 0, 0,0,0};
    vt[11] = '{1,0,0,0,0,4'd0, 0, 9,1,1};
    vt[12] = '{1,0,0,0,0,4'd0, 0, 8,0,1};
    vt[13] = '{1,0,0,0,0,4'd0, 1, 7,0,0};
    vt[14] = '{0,0,0,1,0,4'd0, 0, 0,0,0};
    vt[15] = '{1,0,0,0,0,4'd0, 1, 9,1,1};

    rst = 1'b1;
    set_in(0, 1, 0, 0, 0, 4'd0, 0);
    model_reset();
    #12;
    chk("reset_q16", q16, 0);
    chk("reset_tc16", tc16, 0);
    chk("reset_ovf16", ovf16, 0);
    chk("reset_q9", q9, 0);
    rst = 1'b0;
    #1;

`ifdef T_COUNTER_PRESCALE_EN
    set_in(1, 1, 0, 0, 0, 4'd0, 0);
    for (int k = 1; k <= 12; k++) begin
      cycle();
      chk("pre_q16", q16, k / 4);
    end
    cycle(); cycle();
    en = 1'b0;
    cycle(); cycle();
    en = 1'b1;
    cycle();
    chk("pre_hold_q16", q16, 3);
    cycle();
    chk("pre_step_q16", q16, 4);
`else
    set_in(1, 1, 0, 0, 0, 4'd0, 0);
    for (int k = 1; k <= 17; k++) begin
      cycle();
      chk("wrap_q16", q16, k % 16);
      chk("wrap_tc16", tc16, (k == 16) ? 1 : 0);
      chk("wrap_ovf16", ovf16, (k >= 16) ? 1 : 0);
    end
    for (int k = 0; k < 4; k++) cycle();
    chk("pre_rst_q16", q16, 5);
    chk("pre_rst_ovf16", ovf16, 1);

    #1 rst = 1'b1;
    model_reset();
    #1;
    chk("async_q16", q16, 0);
    chk("async_tc16", tc16, 0);
    chk("async_ovf16", ovf16, 0);
    chk("async_q9", q9, 0);
    @(posedge clk);
    #2;
    chk("rst_hold_q16", q16, 0);
    rst = 1'b0;
    cycle();
    chk("resume_q16", q16, 1);

    clr = 1'b1;
    cycle();
    for (int i = 0; i < 16; i++) begin
      set_in(vt[i].en, vt[i].up, vt[i].sat, vt[i].clr, vt[i].ld, vt[i].lv, vt[i].oc);
      cycle();
      chk($sformatf("vec%0d_q9", i), q9, vt[i].eq);
      chk($sformatf("vec%0d_tc9", i), tc9, vt[i].etc);
      chk($sformatf("vec%0d_ovf9", i), ovf9, vt[i].eov);
    end
`endif

    set_in(1, 1, 0, 0, 0, 4'd0, 0);
    for (int n = 0; n < 500; n++) begin
      en       = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) up_dn = ~up_dn;
      if ($urandom_range(0, 15) == 0) sat_mode = ~sat_mode;
      clr      = ($urandom_range(0, 19) == 0);
      load     = ($urandom_range(0, 11) == 0);
      load_val = 4'($urandom_range(0, 15));
      ovf_clr  = ($urandom_range(0, 7) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
